// File: rtl/dcm_prog_ctrl.sv
// DCM slow-clock program controller: turns inc/dec/set requests into dcm
// update pulses, waits for the dcm to confirm, retries on timeout, flags error.
module dcm_prog_ctrl #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       set_req,
  input  logic [2:0] set_val,
  input  logic       clr_err,
  input  logic [2:0] prog_fb,
  output logic       update,
  output logic [2:0] prog_sel,
  output logic [2:0] cur_prog,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned TMR_W   = 16;
  localparam int unsigned PROG_W  = 3;
  localparam int unsigned RETRY_W = 3;
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [PROG_W-1:0]  PROG_TOP  = PROG_W'(7);
  localparam logic [PROG_W-1:0]  PROG_BOT  = PROG_W'(0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

  state_t              state_q, state_n;
  logic                inc_q, dec_q, set_q;
  logic [PROG_W-1:0]   tgt_n, cur_n;
  logic [TMR_W-1:0]    timer_q, timer_n;
  logic [RETRY_W-1:0]  retry_q, retry_n;
  logic                update_n, done_n, busy_n, err_n;
  logic                req_hit;
  logic [PROG_W-1:0]   req_tgt;

  wire inc_rise = inc & ~inc_q;
  wire dec_rise = dec & ~dec_q;
  wire set_rise = set_req & ~set_q;

  // Edge history registers track input levels even in reset, so a level held
  // through reset release is not seen as a new request.
  always_ff @(posedge clk) begin
    inc_q <= inc;
    dec_q <= dec;
    set_q <= set_req;
  end

  // Request decode with set > inc > dec priority and saturation at 0/7.
  always_comb begin
    req_hit = 1'b0;
    req_tgt = cur_prog;
    if (set_rise) begin
      req_hit = 1'b1;
      req_tgt = set_val;
    end else if (inc_rise) begin
      req_hit = 1'b1;
      req_tgt = (cur_prog == PROG_TOP) ? cur_prog : cur_prog + PROG_W'(1);
    end else if (dec_rise) begin
      req_hit = 1'b1;
      req_tgt = (cur_prog == PROG_BOT) ? cur_prog : cur_prog - PROG_W'(1);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_q;
    tgt_n   = prog_sel;
    cur_n   = cur_prog;
    timer_n = timer_q;
    retry_n = retry_q;
    done_n  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_hit && (req_tgt != cur_prog)) begin
          state_n = S_ISSUE;
          tgt_n   = req_tgt;
          retry_n = '0;
        end
      end
      S_ISSUE: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        timer_n = timer_q + TMR_W'(1);
        if (prog_fb == prog_sel) begin
          state_n = S_IDLE;
          cur_n   = prog_sel;
          done_n  = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_n = retry_q + RETRY_W'(1);
            state_n = S_ISSUE;
          end else begin
            state_n = S_ERR;
          end
        end
      end
      S_ERR: begin
        if (clr_err) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    update_n = (state_n == S_ISSUE);
    busy_n   = (state_n != S_IDLE);
    err_n    = (state_n == S_ERR);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      prog_sel <= '0;
      cur_prog <= '0;
      timer_q  <= '0;
      retry_q  <= '0;
      update   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_n;
      prog_sel <= tgt_n;
      cur_prog <= cur_n;
      timer_q  <= timer_n;
      retry_q  <= retry_n;
      update   <= update_n;
      done     <= done_n;
      busy     <= busy_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Self-checking bench for dcm_prog_ctrl with a behavioural dcm and a
// transaction-level model of the expected controller behaviour.
module tb_dcm_prog_ctrl;

  localparam int T    = 16;
  localparam int MAXR = 2;

  logic       clk;
  logic       rst;
  logic       inc, dec, set_req, clr_err;
  logic [2:0] set_val, prog_fb;
  logic       update, busy, done, err;
  logic [2:0] prog_sel, cur_prog;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [2:0] model_cur;
  logic [2:0] model_sel;

  int         dcm_delay;
  bit         dcm_dead;
  int         pend;
  logic [2:0] pend_val;

  dcm_prog_ctrl #(.TIMEOUT(T), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .set_req(set_req),
    .set_val(set_val), .clr_err(clr_err), .prog_fb(prog_fb),
    .update(update), .prog_sel(prog_sel), .cur_prog(cur_prog),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dcm: adopts prog_sel dcm_delay cycles after an update pulse.
  always @(posedge clk) begin
    if (!rst) begin
      pend    <= 0;
      prog_fb <= 3'd0;
    end else begin
      if (update === 1'b1) begin
        pend     <= dcm_delay;
        pend_val <= prog_sel;
      end else if (pend > 0) begin
        pend <= pend - 1;
      end
      if (pend == 1 && !dcm_dead) prog_fb <= pend_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request; expectations derived from the target rules and dcm timing.
  task automatic do_req(input bit s, input bit i, input bit d, input logic [2:0] sv,
                        input int dly, input bit dead);
    logic [2:0] tgt;
    bit         act, prev_upd, consec, any_busy;
    int         n_upd, n_done, done_k, err_k, last_upd, budget;
    dcm_delay = dly;
    dcm_dead  = dead;
    if (s)      tgt = sv;
    else if (i) tgt = (model_cur == 3'd7) ? 3'd7 : model_cur + 3'd1;
    else        tgt = (model_cur == 3'd0) ? 3'd0 : model_cur - 3'd1;
    act = (tgt != model_cur);
    @(negedge clk);
    set_req = s; inc = i; dec = d; set_val = sv;
    n_upd = 0; n_done = 0; done_k = -1; err_k = -1; last_upd = -100;
    prev_upd = 0; consec = 0; any_busy = 0;
    budget = !act ? 6 : (dead ? (MAXR + 1) * (T + 1) + 6 : dly + 8);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (update === 1'b1) begin
        if (prev_upd) consec = 1;
        check("prog_sel_at_update", 32'(prog_sel), 32'(tgt));
        if (n_upd == 0) check("update_latency", k, 1);
        else            check("retry_spacing", k - last_upd, T + 1);
        n_upd++;
        last_upd = k;
      end
      prev_upd = (update === 1'b1);
      if (busy !== 1'b0) any_busy = 1;
      if (done === 1'b1) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (err === 1'b1 && err_k < 0) err_k = k;
      if (act && k == 1) check("busy_in_issue", 32'(busy), 1);
      if (k == 2) begin set_req = 0; inc = 0; dec = 0; end
      if (act && k == 3) inc = 1;
      if (act && k == 4) inc = 0;
    end
    check("no_consecutive_update", 32'(consec), 0);
    if (!act) begin
      check("noop_updates", n_upd, 0);
      check("noop_busy", 32'(any_busy), 0);
      check("noop_done", n_done, 0);
    end else if (!dead) begin
      check("txn_updates", n_upd, 1);
      check("txn_done_cycle", done_k, dly + 3);
      check("txn_done_count", n_done, 1);
      check("txn_no_err", err_k, -1);
      check("txn_busy_end", 32'(busy), 0);
      model_cur = tgt;
      model_sel = tgt;
    end else begin
      check("dead_updates", n_upd, MAXR + 1);
      check("dead_err_cycle", err_k, 1 + (MAXR + 1) * (T + 1));
      check("dead_no_done", n_done, 0);
      check("dead_err_held", 32'(err), 1);
      check("dead_busy_held", 32'(busy), 1);
      model_sel = tgt;
      // request edge in ERR must be ignored
      inc = 1;
      @(negedge clk);
      check("err_ignores_edge", 32'(update), 0);
      inc = 0;
      clr_err = 1;
      @(negedge clk);
      clr_err = 0;
      check("clr_err_err", 32'(err), 0);
      check("clr_err_busy", 32'(busy), 0);
    end
    check("cur_prog_end", 32'(cur_prog), 32'(model_cur));
    check("prog_sel_end", 32'(prog_sel), 32'(model_sel));
  endtask

  initial begin
    int r;
    logic [2:0] sv;
    rst = 0; inc = 0; dec = 0; set_req = 0; set_val = 0; clr_err = 0;
    dcm_delay = 2; dcm_dead = 0;
    model_cur = 0; model_sel = 0;
    repeat (3) @(negedge clk);
    check("rst_update", 32'(update), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_prog_sel", 32'(prog_sel), 0);
    check("rst_cur_prog", 32'(cur_prog), 0);
    rst = 1;
    @(negedge clk);

    // directed: inc from 0, fb 3 cycles after update
    do_req(0, 1, 0, 3'd0, 2, 0);
    // saturation at 7 and at 0
    do_req(1, 0, 0, 3'd7, 4, 0);
    do_req(0, 1, 0, 3'd0, 4, 0);
    do_req(1, 0, 0, 3'd0, 1, 0);
    do_req(0, 0, 1, 3'd0, 4, 0);
    // same set_val as current: no transaction
    do_req(1, 0, 0, 3'd0, 4, 0);
    // simultaneous edges, set wins
    do_req(1, 1, 1, 3'd5, 3, 0);
    // match on the last timer cycle beats timeout
    do_req(0, 0, 1, 3'd0, T - 1, 0);
    // dead dcm: retries then error
    do_req(1, 0, 0, 3'd3, 2, 1);

    // reset in the middle of WAIT, with inc held through release
    dcm_dead = 1;
    sv = model_cur ^ 3'd4;
    @(negedge clk); set_req = 1; set_val = sv;
    repeat (6) @(negedge clk);
    set_req = 0;
    check("pre_rst_busy", 32'(busy), 1);
    rst = 0; inc = 1;
    @(negedge clk);
    check("midrst_update", 32'(update), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_prog_sel", 32'(prog_sel), 0);
    check("midrst_cur_prog", 32'(cur_prog), 0);
    rst = 1;
    model_cur = 0; model_sel = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("held_inc_no_update", 32'(update), 0);
      check("held_inc_no_busy", 32'(busy), 0);
    end
    inc = 0;
    @(negedge clk);
    do_req(0, 1, 0, 3'd0, 3, 0);

    // randomized requests
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(1, 7);
      do_req(r[2], r[1], r[0], 3'($urandom_range(0, 7)),
             ($urandom_range(0, 4) == 0) ? T - 1 : $urandom_range(1, T - 1),
             $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcm_prog_ctrl.md
DCM_PROG_CTRL -- requirements
Module: dcm_prog_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024, is the number of clk cycles to wait for dcm confirmation after each update (legal range 2..65535).
REQ-002 Parameter MAX_RETRY, default 2, is the number of re-issues allowed after the first timeout before an error is flagged (legal range 0..7).
REQ-003 Port clk, input, 1 bit: single system clock (100 MHz); all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port inc, input, 1 bit: level request to step the slow-clock setting up; the block acts on its rising edge.
REQ-006 Port dec, input, 1 bit: level request to step the slow-clock setting down; the block acts on its rising edge.
REQ-007 Port set_req, input, 1 bit: level request to load set_val directly; the block acts on its rising edge.
REQ-008 Port set_val, input, 3 bits: absolute target setting, sampled on the cycle the set_req edge is detected.
REQ-009 Port clr_err, input, 1 bit: clears the error state.
REQ-010 Port prog_fb, input, 3 bits: setting currently generated by the dcm (its prog_out).
REQ-011 Port update, output, 1 bit: one-cycle pulse to the dcm update input.
REQ-012 Port prog_sel, output, 3 bits: value driven to the dcm prog_in.
REQ-013 Port cur_prog, output, 3 bits: last confirmed setting.
REQ-014 Port busy, output, 1 bit: high when the FSM is in any state other than IDLE.
REQ-015 Port done, output, 1 bit: one-cycle pulse when a change is confirmed.
REQ-016 Port err, output, 1 bit: high while the FSM is in ERR.

Function
REQ-017 Edge detection: inc, dec and set_req each have a registered copy; rise = input high AND registered copy low.
REQ-018 FSM states are IDLE, ISSUE, WAIT and ERR.
REQ-019 Edges are evaluated only in IDLE; edges in other states are discarded and never queued.
REQ-020 Priority among simultaneous edges: set_req > inc > dec; lower-priority edges in the same cycle are discarded.
REQ-021 Target value:
- set: target = set_val.
- inc: target = cur_prog+1, saturating at 7.
- dec: target = cur_prog-1, saturating at 0.
REQ-022 If target equals cur_prog (saturation case or same set_val), the FSM stays in IDLE, and no update or done pulse is generated.
REQ-023 IDLE to ISSUE: target is latched into the target register, and retry_cnt is cleared.
REQ-024 ISSUE lasts exactly one cycle:
- update = 1 and prog_sel = target.
- the wait timer is cleared.
- next state is WAIT.
REQ-025 prog_sel holds the target register value in every state; it changes only on entry to ISSUE from IDLE.
REQ-026 WAIT:
- the 16-bit timer increments every cycle.
- prog_fb is compared with target every cycle.
REQ-027 A match in WAIT has priority over timeout in the same cycle:
- next state is IDLE and cur_prog <= target.
- done pulses 1 the following cycle.
REQ-028 Timeout occurs when the timer equals TIMEOUT-1 with no match:
- if retry_cnt < MAX_RETRY: retry_cnt increments and next state is ISSUE.
- otherwise: next state is ERR.
REQ-029 ERR:
- err = 1 and busy = 1; cur_prog is unchanged.
- clr_err = 1 returns the FSM to IDLE on the next cycle.
- all request edges are discarded while in ERR.
REQ-030 update is never high for two consecutive cycles.
REQ-031 Latency: a request edge detected in cycle N gives update = 1 in cycle N+1.

Reset
REQ-032 When rst = 0 at a rising clk edge, the block enters IDLE from any state, including mid-WAIT or ERR, with:
- update = 0, done = 0, err = 0, busy = 0.
- prog_sel = 0, cur_prog = 0.
- timer = 0, retry_cnt = 0.
REQ-033 During reset, the edge registers load the current inc, dec and set_req levels, so an input held high through reset produces no edge after reset is released.

Verification
REQ-034 inc edge with prog_fb following update by 3 cycles -> single update pulse, prog_sel = 1, done pulse, cur_prog = 1, busy returns to 0.
REQ-035 cur_prog = 7 and an inc edge -> no update pulse, busy stays 0; likewise cur_prog = 0 and a dec edge.
REQ-036 set_req, inc and dec rise in the same cycle with set_val = 5 -> prog_sel = 5, exactly one transaction runs.
REQ-037 TIMEOUT = 16, MAX_RETRY = 2, prog_fb held at 0, set_val = 3 -> three update pulses 17 cycles apart, then err = 1; clr_err -> IDLE with cur_prog = 0.
REQ-038 rst = 0 asserted mid-WAIT -> next cycle all outputs at reset values; a later inc edge starts a fresh transaction with prog_sel = 1.
